// File: rtl/ctrl_seq.sv
// Multi-cycle control sequencer: fetches 16-bit instructions, decodes them into the
// datapath control word and constant operand, and sequences the PC including branches.
module ctrl_seq #(
  parameter logic [15:0] RESET_PC      = 16'h0000,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] Iin,
  input  logic        Ivalid,
  input  logic        V,
  input  logic        C,
  input  logic        N,
  input  logic        Z,
  output logic        Ireq,
  output logic [15:0] PCout,
  output logic [15:0] CTRWRD,
  output logic [15:0] Cin,
  output logic        MW,
  output logic        HALTED,
  output logic        FAULT
);

  localparam int unsigned IW = 16;
  localparam int unsigned CW = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT + 1);

  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_ADI = 4'h8;
  localparam logic [3:0] OP_LDI = 4'h9;
  localparam logic [3:0] OP_LD  = 4'hA;
  localparam logic [3:0] OP_ST  = 4'hB;
  localparam logic [3:0] OP_BRZ = 4'hC;
  localparam logic [3:0] OP_BRN = 4'hD;
  localparam logic [3:0] OP_JMP = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EX1   = 3'd1,
    S_EX2   = 3'd2,
    S_HALT  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_pc, w_pc_nxt;
  logic [IW-1:0]   r_ir, w_ir_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
  logic            r_ireq, w_ireq_nxt;
  logic [IW-1:0]   r_ctrwrd, w_ctrwrd_nxt;
  logic [IW-1:0]   r_cin, w_cin_nxt;
  logic            r_mw, w_mw_nxt;
  logic            r_halted, r_fault;
  logic [IW-1:0]   w_off;
  logic            w_taken;
  logic            w_unused_flags;

  // {DA,AA,BA,MB,FS,MD,RW}; wr_phase is RW for register-writing ops
  function automatic logic [15:0] decode_word(input logic [15:0] ir, input logic wr_phase);
    logic [2:0] dr, sa, sb;
    logic [15:0] w;
    dr = ir[11:9];
    sa = ir[8:6];
    sb = ir[5:3];
    w  = '0;
    case (ir[15:12])
      OP_MOV:  w = {dr,   sa,   3'd0, 1'b0, 4'b0000, 1'b0, wr_phase};
      OP_ADD:  w = {dr,   sa,   sb,   1'b0, 4'b0010, 1'b0, wr_phase};
      OP_SUB:  w = {dr,   sa,   sb,   1'b0, 4'b0101, 1'b0, wr_phase};
      OP_AND:  w = {dr,   sa,   sb,   1'b0, 4'b1000, 1'b0, wr_phase};
      OP_OR:   w = {dr,   sa,   sb,   1'b0, 4'b1001, 1'b0, wr_phase};
      OP_XOR:  w = {dr,   sa,   sb,   1'b0, 4'b1010, 1'b0, wr_phase};
      OP_NOT:  w = {dr,   sa,   3'd0, 1'b0, 4'b1011, 1'b0, wr_phase};
      OP_ADI:  w = {dr,   sa,   3'd0, 1'b1, 4'b0010, 1'b0, wr_phase};
      OP_LDI:  w = {dr,   3'd0, 3'd0, 1'b1, 4'b1100, 1'b0, wr_phase};
      OP_LD:   w = {dr,   sa,   3'd0, 1'b0, 4'b0000, 1'b1, wr_phase};
      OP_ST:   w = {3'd0, sa,   sb,   1'b0, 4'b0000, 1'b0, 1'b0};
      default: w = '0;
    endcase
    return w;
  endfunction

  // V and C are part of the flag bus but no current opcode branches on them
  assign w_unused_flags = V ^ C;

  assign w_off     = {{7{r_ir[8]}}, r_ir[8:0]};
  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_taken   = ((r_ir[15:12] == OP_BRZ) && Z) ||
                     ((r_ir[15:12] == OP_BRN) && N) ||
                      (r_ir[15:12] == OP_JMP);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state  <= S_FETCH;
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_cnt    <= '0;
      r_ireq   <= 1'b1;
      r_ctrwrd <= '0;
      r_cin    <= '0;
      r_mw     <= 1'b0;
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_ir     <= w_ir_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ireq   <= w_ireq_nxt;
      r_ctrwrd <= w_ctrwrd_nxt;
      r_cin    <= w_cin_nxt;
      r_mw     <= w_mw_nxt;
      r_halted <= r_halted | (w_state_nxt == S_HALT);
      r_fault  <= r_fault  | (w_state_nxt == S_FAULT);
    end
  end

  // Next state, then outputs registered for the state being entered
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_ir_nxt     = r_ir;
    w_cnt_nxt    = r_cnt;
    w_ireq_nxt   = 1'b0;
    w_ctrwrd_nxt = '0;
    w_cin_nxt    = '0;
    w_mw_nxt     = 1'b0;

    case (r_state)
      S_FETCH: begin
        if (Ivalid) begin
          w_ir_nxt    = Iin;
          w_pc_nxt    = r_pc + IW'(1);
          w_cnt_nxt   = '0;
          w_state_nxt = S_EX1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if ((FETCH_TIMEOUT != 0) && (w_cnt_inc == CW'(FETCH_TIMEOUT))) begin
            w_state_nxt = S_FAULT;
          end
        end
      end
      S_EX1: begin
        if (r_ir[15:12] == OP_HLT) begin
          w_state_nxt = S_HALT;
        end else begin
          w_state_nxt = S_EX2;
          if (w_taken) begin
            w_pc_nxt = r_pc + w_off;
          end
        end
      end
      S_EX2:   w_state_nxt = S_FETCH;
      S_HALT:  w_state_nxt = S_HALT;
      S_FAULT: w_state_nxt = S_FAULT;
      default: w_state_nxt = S_FAULT;
    endcase

    case (w_state_nxt)
      S_FETCH: w_ireq_nxt = 1'b1;
      S_EX1, S_EX2: begin
        w_ctrwrd_nxt = decode_word(w_ir_nxt, w_state_nxt == S_EX2);
        if ((w_ir_nxt[15:12] == OP_ADI) || (w_ir_nxt[15:12] == OP_LDI)) begin
          w_cin_nxt = {10'd0, w_ir_nxt[5:0]};
        end
        w_mw_nxt = (w_state_nxt == S_EX2) && (w_ir_nxt[15:12] == OP_ST);
      end
      default: ;
    endcase
  end

  assign Ireq   = r_ireq;
  assign PCout  = r_pc;
  assign CTRWRD = r_ctrwrd;
  assign Cin    = r_cin;
  assign MW     = r_mw;
  assign HALTED = r_halted;
  assign FAULT  = r_fault;

endmodule

// File: tb/tb_ctrl_seq.sv
// Bench for ctrl_seq: vector table, corner-case sequences (reset, halt, fault),
// and randomized instruction streams checked against an opcode-table model.
module tb_ctrl_seq;

  logic        CLK;
  logic        RESET;
  logic [15:0] Iin;
  logic        Ivalid;
  logic        V, C, N, Z;
  logic        Ireq;
  logic [15:0] PCout;
  logic [15:0] CTRWRD;
  logic [15:0] Cin;
  logic        MW;
  logic        HALTED;
  logic        FAULT;

  int n_pass;
  int n_total;

  ctrl_seq #(.RESET_PC(16'h0000), .FETCH_TIMEOUT(16)) dut (
    .CLK(CLK), .RESET(RESET), .Iin(Iin), .Ivalid(Ivalid),
    .V(V), .C(C), .N(N), .Z(Z),
    .Ireq(Ireq), .PCout(PCout), .CTRWRD(CTRWRD), .Cin(Cin),
    .MW(MW), .HALTED(HALTED), .FAULT(FAULT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference tables indexed by opcode
  localparam logic [3:0]  FS_T [16] = '{4'h0, 4'h0, 4'h2, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB,
                                        4'h2, 4'hC, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
  localparam logic [15:0] M_DR = 16'h07FE;
  localparam logic [15:0] M_SA = 16'h0DFE;
  localparam logic [15:0] M_SB = 16'h087C;
  localparam logic [15:0] M_MB = 16'h0300;
  localparam logic [15:0] M_MD = 16'h0400;
  localparam logic [15:0] M_WR = 16'h07FE;

  typedef struct {
    logic [15:0] ins;
    logic        z;
    logic        n;
    logic [15:0] w1;
    logic [15:0] w2;
    logic [15:0] cin;
    logic        mw;
    logic [15:0] pc;
  } vec_t;

  vec_t vt[$];

  function automatic logic [15:0] m_word(input logic [15:0] ins, input bit ex2);
    int op;
    logic [15:0] w;
    op = int'(ins[15:12]);
    w  = '0;
    if (M_DR[op]) w[15:13] = ins[11:9];
    if (M_SA[op]) w[12:10] = ins[8:6];
    if (M_SB[op]) w[9:7]   = ins[5:3];
    w[6]   = M_MB[op];
    w[5:2] = FS_T[op];
    w[1]   = M_MD[op];
    w[0]   = ex2 & M_WR[op];
    return w;
  endfunction

  function automatic logic [15:0] m_next_pc(input logic [15:0] pc, input logic [15:0] ins,
                                            input logic z, input logic n);
    int t;
    int off;
    bit taken;
    t     = int'(pc) + 1;
    off   = int'(ins[8:0]);
    if (ins[8]) off = off - 512;
    taken = (ins[15:12] == 4'hC && z) || (ins[15:12] == 4'hD && n) || (ins[15:12] == 4'hE);
    if (taken) t = t + off;
    return 16'(t);
  endfunction

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET  = 1'b0;
    Ivalid = 1'b0;
    tick();
    tick();
    RESET = 1'b1;
  endtask

  task automatic chk_reset(input string tag);
    chk16({tag, " pc"},     PCout,  16'h0000);
    chk1 ({tag, " ireq"},   Ireq,   1'b1);
    chk16({tag, " word"},   CTRWRD, 16'h0000);
    chk16({tag, " cin"},    Cin,    16'h0000);
    chk1 ({tag, " mw"},     MW,     1'b0);
    chk1 ({tag, " halted"}, HALTED, 1'b0);
    chk1 ({tag, " fault"},  FAULT,  1'b0);
  endtask

  // One full FETCH/EX1/EX2 instruction with checks in every phase
  task automatic exec(input string tag, input logic [15:0] ins, input logic z, input logic n,
                      input int wt, input bit noisy,
                      input logic [15:0] e_w1, input logic [15:0] e_w2,
                      input logic [15:0] e_cin, input logic e_mw, input logic [15:0] e_pc);
    Ivalid = 1'b0;
    repeat (wt) begin
      Iin = 16'($urandom);
      tick();
    end
    chk1 ({tag, " fetch ireq"}, Ireq,   1'b1);
    chk16({tag, " fetch word"}, CTRWRD, 16'h0000);
    Iin    = ins;
    Ivalid = 1'b1;
    tick();
    Z = z;
    N = n;
    V = 1'($urandom);
    C = 1'($urandom);
    if (noisy) begin Ivalid = 1'($urandom); Iin = 16'($urandom); end
    else Ivalid = 1'b0;
    chk16({tag, " ex1 word"}, CTRWRD, e_w1);
    chk16({tag, " ex1 cin"},  Cin,    e_cin);
    chk1 ({tag, " ex1 mw"},   MW,     1'b0);
    chk1 ({tag, " ex1 ireq"}, Ireq,   1'b0);
    tick();
    if (noisy) begin Ivalid = 1'($urandom); Iin = 16'($urandom); end
    chk16({tag, " ex2 word"}, CTRWRD, e_w2);
    chk16({tag, " ex2 cin"},  Cin,    e_cin);
    chk1 ({tag, " ex2 mw"},   MW,     e_mw);
    chk16({tag, " ex2 pc"},   PCout,  e_pc);
    tick();
    Ivalid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] ins;
    logic [15:0] mpc;
    logic        z, n;
    logic [15:0] ecin;

    n_pass = 0;
    n_total = 0;
    RESET = 1'b0; Iin = '0; Ivalid = 1'b0; V = 0; C = 0; N = 0; Z = 0;

    //              ins      z     n     w1        w2        cin       mw    pc
    vt.push_back(vec_t'{16'h2298, 1'b0, 1'b0, 16'h2988, 16'h2989, 16'h0000, 1'b0, 16'h0001});
    vt.push_back(vec_t'{16'h8285, 1'b0, 1'b0, 16'h2848, 16'h2849, 16'h0005, 1'b0, 16'h0002});
    vt.push_back(vec_t'{16'hB098, 1'b0, 1'b0, 16'h0980, 16'h0980, 16'h0000, 1'b1, 16'h0003});
    vt.push_back(vec_t'{16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0004});
    vt.push_back(vec_t'{16'h1E40, 1'b0, 1'b0, 16'hE400, 16'hE401, 16'h0000, 1'b0, 16'h0005});
    vt.push_back(vec_t'{16'h3A5F, 1'b0, 1'b0, 16'hA594, 16'hA595, 16'h0000, 1'b0, 16'h0006});
    vt.push_back(vec_t'{16'h4000, 1'b0, 1'b0, 16'h0020, 16'h0021, 16'h0000, 1'b0, 16'h0007});
    vt.push_back(vec_t'{16'h5000, 1'b0, 1'b0, 16'h0024, 16'h0025, 16'h0000, 1'b0, 16'h0008});
    vt.push_back(vec_t'{16'h6000, 1'b0, 1'b0, 16'h0028, 16'h0029, 16'h0000, 1'b0, 16'h0009});
    vt.push_back(vec_t'{16'h7000, 1'b0, 1'b0, 16'h002C, 16'h002D, 16'h0000, 1'b0, 16'h000A});
    vt.push_back(vec_t'{16'h9E3F, 1'b0, 1'b0, 16'hE070, 16'hE071, 16'h003F, 1'b0, 16'h000B});
    vt.push_back(vec_t'{16'hA440, 1'b0, 1'b0, 16'h4402, 16'h4403, 16'h0000, 1'b0, 16'h000C});
    vt.push_back(vec_t'{16'hC1FE, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h000D});
    vt.push_back(vec_t'{16'hD003, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h000E});
    vt.push_back(vec_t'{16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h000F});
    vt.push_back(vec_t'{16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0010});
    vt.push_back(vec_t'{16'hC1FE, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h000F});
    vt.push_back(vec_t'{16'hD1FF, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h000F});
    vt.push_back(vec_t'{16'hE002, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0012});
    vt.push_back(vec_t'{16'hE1EC, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'hFFFF});
    vt.push_back(vec_t'{16'hE001, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0001});
    vt.push_back(vec_t'{16'hC1FE, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0002});

    do_reset();
    chk_reset("reset");

    for (int i = 0; i < vt.size(); i++) begin
      exec($sformatf("vec%0d", i), vt[i].ins, vt[i].z, vt[i].n, i % 3, 1'b0,
           vt[i].w1, vt[i].w2, vt[i].cin, vt[i].mw, vt[i].pc);
    end

    // Timeout counter must clear on every successful fetch
    do_reset();
    exec("wait10a", 16'h0000, 1'b0, 1'b0, 10, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0001);
    exec("wait10b", 16'h0000, 1'b0, 1'b0, 10, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0002);
    chk1("no fault after cleared count", FAULT, 1'b0);

    // Fetch timeout, then FAULT is terminal even with Ivalid pulsed
    do_reset();
    repeat (15) tick();
    chk1("fault at 15", FAULT, 1'b0);
    chk1("ireq at 15",  Ireq,  1'b1);
    tick();
    chk1("fault at 16", FAULT, 1'b1);
    chk1("ireq at 16",  Ireq,  1'b0);
    Iin = 16'h2298;
    Ivalid = 1'b1;
    repeat (4) tick();
    Ivalid = 1'b0;
    chk1 ("fault sticky",   FAULT,  1'b1);
    chk1 ("fault ireq",     Ireq,   1'b0);
    chk16("fault pc",       PCout,  16'h0000);
    chk16("fault word",     CTRWRD, 16'h0000);
    chk1 ("fault halted",   HALTED, 1'b0);
    do_reset();
    chk_reset("reset from fault");

    // HALT is terminal and never times out
    Iin = 16'hF000;
    Ivalid = 1'b1;
    tick();
    Ivalid = 1'b0;
    chk16("halt ex1 word",   CTRWRD, 16'h0000);
    chk1 ("halt ex1 halted", HALTED, 1'b0);
    chk16("halt ex1 pc",     PCout,  16'h0001);
    tick();
    chk1 ("halted set",  HALTED, 1'b1);
    chk1 ("halt ireq",   Ireq,   1'b0);
    chk16("halt word",   CTRWRD, 16'h0000);
    Iin = 16'h2298;
    Ivalid = 1'b1;
    repeat (20) tick();
    Ivalid = 1'b0;
    chk1 ("halt sticky",   HALTED, 1'b1);
    chk1 ("halt no fault", FAULT,  1'b0);
    chk16("halt pc",       PCout,  16'h0001);
    chk1 ("halt mw",       MW,     1'b0);
    do_reset();
    chk_reset("reset from halt");

    // Reset asserted during EX2
    Iin = 16'h2298;
    Ivalid = 1'b1;
    tick();
    Ivalid = 1'b0;
    tick();
    chk16("pre-reset ex2 word", CTRWRD, 16'h2989);
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    chk16("ex2 reset word", CTRWRD, 16'h0000);
    chk16("ex2 reset pc",   PCout,  16'h0000);
    chk1 ("ex2 reset ireq", Ireq,   1'b1);
    exec("after ex2 reset", 16'h2298, 1'b0, 1'b0, 0, 1'b0,
         16'h2988, 16'h2989, 16'h0000, 1'b0, 16'h0001);

    // Randomized stream against the table model
    do_reset();
    mpc = 16'h0000;
    for (int i = 0; i < 150; i++) begin
      ins  = {4'($urandom_range(0, 14)), 12'($urandom)};
      z    = 1'($urandom);
      n    = 1'($urandom);
      mpc  = m_next_pc(mpc, ins, z, n);
      ecin = (ins[15:12] == 4'h8 || ins[15:12] == 4'h9) ? {10'd0, ins[5:0]} : 16'h0000;
      exec($sformatf("rnd%0d op%h", i, ins[15:12]), ins, z, n, $urandom_range(0, 3), 1'b1,
           m_word(ins, 1'b0), m_word(ins, 1'b1), ecin, ins[15:12] == 4'hB, mpc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
